// File: rtl/renkon_conv_seq_pkg.sv
// rtl/renkon_conv_seq_pkg.sv - shared constants and state encoding for the conv sequencer
package renkon_conv_seq_pkg;

  localparam int DWIDTH   = 16;  // datapath width of the conv unit; not used by the sequencer
  localparam int FACCUM   = 10;  // feature-memory address width
  localparam int WADDR    = 12;  // weight-memory address width
  localparam int CHWIDTH  = 8;   // input-channel count width
  localparam int FSIZE2   = 25;  // 5x5 kernel taps per channel
  localparam int TREE_LAT = 4;   // win_en to valid tree result; must be >= 2

  localparam int KWIDTH   = $clog2(FSIZE2);
  localparam int DCWIDTH  = $clog2(TREE_LAT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WLOAD = 3'd1,
    WLAST = 3'd2,
    CONV  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/renkon_conv_seq_dline.sv
// rtl/renkon_conv_seq_dline.sv - tag delay line matching the conv tree latency
module renkon_conv_seq_dline #(
  parameter int DEPTH = 3,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          xrst,
  input  logic          in_valid,
  input  logic          in_first,
  input  logic          in_last,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic          out_first,
  output logic          out_last,
  output logic [AW-1:0] out_addr
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] fst;
  logic [DEPTH-1:0] lst;
  logic [AW-1:0]    adr [DEPTH];

  // Shift tags every cycle; an address field only moves with a valid tag,
  // so every stage keeps the most recent valid address.
  always_ff @(posedge clk) begin
    if (xrst) begin
      vld <= '0;
      fst <= '0;
      lst <= '0;
      for (int i = 0; i < DEPTH; i++) adr[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      fst[0] <= in_first;
      lst[0] <= in_last;
      if (in_valid) adr[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        fst[i] <= fst[i-1];
        lst[i] <= lst[i-1];
        if (vld[i-1]) adr[i] <= adr[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_first = fst[DEPTH-1];
  assign out_last  = lst[DEPTH-1];
  assign out_addr  = adr[DEPTH-1];

endmodule

// File: rtl/renkon_conv_seq.sv
// rtl/renkon_conv_seq.sv - weight-load and output-sweep sequencer for one conv unit
module renkon_conv_seq
  import renkon_conv_seq_pkg::*;
(
  input  logic               clk,
  input  logic               xrst,
  input  logic               req,
  input  logic [CHWIDTH-1:0] in_ch,
  input  logic [FACCUM:0]    feat_cnt,
  input  logic [WADDR-1:0]   w_base,
  output logic               ack,
  output logic [WADDR-1:0]   w_addr,
  output logic               wreg_we,
  output logic               chan_start,
  output logic               win_en,
  output logic [FACCUM-1:0]  mem_feat_addr,
  output logic               mem_feat_rst,
  output logic [FACCUM-1:0]  mem_feat_addr_d1,
  output logic               mem_feat_we,
  output logic               out_en
);

  state_t             state;
  state_t             state_nxt;
  logic [CHWIDTH-1:0] ch_num;
  logic [CHWIDTH-1:0] ch_idx;
  logic [FACCUM:0]    feat_num;
  logic [FACCUM:0]    pos;
  logic [WADDR-1:0]   ch_base;
  logic [KWIDTH-1:0]  tap;
  logic [DCWIDTH-1:0] drn;
  logic               zero_cnt;
  logic               last_tap;
  logic               last_pos;
  logic               last_drn;
  logic               more_ch;
  logic               dl_valid;
  logic               dl_first;
  logic               dl_last;
  logic [FACCUM-1:0]  dl_addr;

  assign last_tap = (tap == KWIDTH'(FSIZE2 - 1));
  assign last_pos = (pos == feat_num - (FACCUM+1)'(1));
  assign last_drn = (drn == DCWIDTH'(TREE_LAT - 1));
  assign more_ch  = ((CHWIDTH+1)'(ch_idx) + (CHWIDTH+1)'(1)) < (CHWIDTH+1)'(ch_num);

  // ch_base already carries w_base + c*FSIZE2, so adding the tap wraps naturally
  assign w_addr = ch_base + WADDR'(tap);

  // State register
  always_ff @(posedge clk) begin
    if (xrst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode and state-derived strobes
  always_comb begin
    state_nxt  = state;
    ack        = 1'b0;
    chan_start = 1'b0;
    win_en     = 1'b0;
    case (state)
      IDLE: begin
        ack = 1'b1;
        if (req) state_nxt = WLOAD;
      end
      WLOAD: begin
        if (zero_cnt)      state_nxt = DONE;
        else if (last_tap) state_nxt = WLAST;
      end
      WLAST: begin
        chan_start = 1'b1;
        state_nxt  = CONV;
      end
      CONV: begin
        win_en = 1'b1;
        if (last_pos) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_drn) state_nxt = more_ch ? WLOAD : DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job latch, tap/position/drain counters and the weight-shift strobe
  always_ff @(posedge clk) begin
    if (xrst) begin
      ch_num   <= '0;
      feat_num <= '0;
      ch_base  <= '0;
      zero_cnt <= 1'b0;
      ch_idx   <= '0;
      tap      <= '0;
      pos      <= '0;
      drn      <= '0;
      wreg_we  <= 1'b0;
    end else begin
      // weight memory returns data one cycle after the address
      wreg_we <= (state == WLOAD) && !zero_cnt;
      case (state)
        IDLE: begin
          if (req) begin
            ch_num   <= in_ch;
            feat_num <= feat_cnt;
            ch_base  <= w_base;
            zero_cnt <= (in_ch == '0) || (feat_cnt == '0);
            ch_idx   <= '0;
            tap      <= '0;
            pos      <= '0;
            drn      <= '0;
          end
        end
        WLOAD: tap <= last_tap ? '0 : tap + 1'b1;
        CONV:  pos <= last_pos ? '0 : pos + 1'b1;
        DRAIN: begin
          drn <= last_drn ? '0 : drn + 1'b1;
          if (last_drn && more_ch) begin
            ch_idx  <= ch_idx + 1'b1;
            ch_base <= ch_base + WADDR'(FSIZE2);
          end
        end
        default: ;
      endcase
    end
  end

  renkon_conv_seq_dline #(
    .DEPTH (TREE_LAT - 1),
    .AW    (FACCUM)
  ) u_dline (
    .clk       (clk),
    .xrst      (xrst),
    .in_valid  (win_en),
    .in_first  (ch_idx == '0),
    .in_last   (!more_ch),
    .in_addr   (pos[FACCUM-1:0]),
    .out_valid (dl_valid),
    .out_first (dl_first),
    .out_last  (dl_last),
    .out_addr  (dl_addr)
  );

  assign mem_feat_addr = dl_addr;
  assign mem_feat_rst  = dl_valid & dl_first;

  // Write side trails the read side by one cycle; write address holds when idle
  always_ff @(posedge clk) begin
    if (xrst) begin
      mem_feat_addr_d1 <= '0;
      mem_feat_we      <= 1'b0;
      out_en           <= 1'b0;
    end else begin
      mem_feat_we <= dl_valid;
      out_en      <= dl_valid & dl_last;
      if (dl_valid) mem_feat_addr_d1 <= dl_addr;
    end
  end

endmodule

// File: tb/tb_renkon_conv_seq.sv
// tb/tb_renkon_conv_seq.sv - directed self-checking bench for renkon_conv_seq
module tb_renkon_conv_seq;

  localparam int TL = 4;   // tree latency of the DUT build
  localparam int K2 = 25;  // taps per channel

  logic        clk = 1'b0;
  logic        xrst;
  logic        req;
  logic [7:0]  in_ch;
  logic [10:0] feat_cnt;
  logic [11:0] w_base;
  logic        ack;
  logic [11:0] w_addr;
  logic        wreg_we;
  logic        chan_start;
  logic        win_en;
  logic [9:0]  mem_feat_addr;
  logic        mem_feat_rst;
  logic [9:0]  mem_feat_addr_d1;
  logic        mem_feat_we;
  logic        out_en;

  always #5 clk = ~clk;

  renkon_conv_seq dut (
    .clk              (clk),
    .xrst             (xrst),
    .req              (req),
    .in_ch            (in_ch),
    .feat_cnt         (feat_cnt),
    .w_base           (w_base),
    .ack              (ack),
    .w_addr           (w_addr),
    .wreg_we          (wreg_we),
    .chan_start       (chan_start),
    .win_en           (win_en),
    .mem_feat_addr    (mem_feat_addr),
    .mem_feat_rst     (mem_feat_rst),
    .mem_feat_addr_d1 (mem_feat_addr_d1),
    .mem_feat_we      (mem_feat_we),
    .out_en           (out_en)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int cyc, wreg_cnt, win_cnt, we_cnt, cs_cnt, rst_cnt, oe_cnt, ack_low, drain_viol;
  int          q_win[$];
  int          q_cs[$];
  int          q_we_cyc[$];
  logic [11:0] q_waddr[$];
  logic [9:0]  q_we_addr[$];
  logic [9:0]  q_rd_addr[$];
  logic        q_rd_rst[$];
  logic        q_we_out[$];
  logic [11:0] prev_w_addr;
  logic [9:0]  prev_rd_addr;
  logic        prev_rd_rst;

  // Observe strobes away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (!ack) ack_low++;
    if (wreg_we) begin
      wreg_cnt++;
      q_waddr.push_back(prev_w_addr);
      if (win_cnt > we_cnt) drain_viol++;
    end
    if (win_en) begin
      win_cnt++;
      q_win.push_back(cyc);
    end
    if (chan_start) begin
      cs_cnt++;
      q_cs.push_back(cyc);
    end
    if (mem_feat_rst) rst_cnt++;
    if (out_en) oe_cnt++;
    if (mem_feat_we) begin
      we_cnt++;
      q_we_cyc.push_back(cyc);
      q_we_addr.push_back(mem_feat_addr_d1);
      q_we_out.push_back(out_en);
      q_rd_addr.push_back(prev_rd_addr);
      q_rd_rst.push_back(prev_rd_rst);
    end
    prev_w_addr  = w_addr;
    prev_rd_addr = mem_feat_addr;
    prev_rd_rst  = mem_feat_rst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wreg_cnt = 0; win_cnt = 0; we_cnt = 0; cs_cnt = 0;
    rst_cnt = 0; oe_cnt = 0; ack_low = 0; drain_viol = 0;
    q_win.delete(); q_cs.delete(); q_we_cyc.delete(); q_waddr.delete();
    q_we_addr.delete(); q_rd_addr.delete(); q_rd_rst.delete(); q_we_out.delete();
  endtask

  task automatic start_req(input int nch, input int nf, input int base);
    @(posedge clk); #1;
    in_ch    = 8'(nch);
    feat_cnt = 11'(nf);
    w_base   = 12'(base);
    req      = 1'b1;
    @(posedge clk); #1;
    req      = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_run(input string tag, input int nch, input int nf, input int base);
    int zero, np, nw, c, p, lim;
    logic [11:0] ea;
    zero = (nch == 0 || nf == 0) ? 1 : 0;
    np   = zero ? 0 : nch * nf;
    nw   = zero ? 0 : nch * K2;
    // per channel: 25 WLOAD + WLAST + nf CONV + TL DRAIN; then DONE
    chk({tag, "_ack_low"}, 32'(ack_low), zero ? 32'd2 : 32'(nch * (K2 + 1 + nf + TL) + 1));
    chk({tag, "_wreg_cnt"}, 32'(wreg_cnt), 32'(nw));
    chk({tag, "_win_cnt"}, 32'(win_cnt), 32'(np));
    chk({tag, "_we_cnt"}, 32'(we_cnt), 32'(np));
    chk({tag, "_cs_cnt"}, 32'(cs_cnt), zero ? 32'd0 : 32'(nch));
    chk({tag, "_rst_cnt"}, 32'(rst_cnt), zero ? 32'd0 : 32'(nf));
    chk({tag, "_oe_cnt"}, 32'(oe_cnt), zero ? 32'd0 : 32'(nf));
    chk({tag, "_drain_wreg"}, 32'(drain_viol), 32'd0);
    lim = (q_waddr.size() < nw) ? q_waddr.size() : nw;
    for (int j = 0; j < lim; j++) begin
      ea = 12'(base + K2 * (j / K2) + (j % K2));
      chk($sformatf("%s_waddr%0d", tag, j), 32'(q_waddr[j]), 32'(ea));
    end
    lim = (q_we_cyc.size() < q_win.size()) ? q_we_cyc.size() : q_win.size();
    if (lim > np) lim = np;
    for (int j = 0; j < lim; j++) begin
      c = j / nf;
      p = j % nf;
      chk($sformatf("%s_we_lat%0d", tag, j), 32'(q_we_cyc[j] - q_win[j]), 32'(TL));
      chk($sformatf("%s_rd_addr%0d", tag, j), 32'(q_rd_addr[j]), 32'(p));
      chk($sformatf("%s_rd_rst%0d", tag, j), 32'(q_rd_rst[j]), 32'(c == 0));
      chk($sformatf("%s_wr_addr%0d", tag, j), 32'(q_we_addr[j]), 32'(p));
      chk($sformatf("%s_out_en%0d", tag, j), 32'(q_we_out[j]), 32'(c == nch - 1));
    end
    for (int j = 0; j < q_cs.size(); j++) begin
      if (j * nf < q_win.size())
        chk($sformatf("%s_cs_lead%0d", tag, j), 32'(q_win[j * nf] - q_cs[j]), 32'd1);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'd1);
    chk({tag, "_wreg_we"}, 32'(wreg_we), 32'd0);
    chk({tag, "_chan_start"}, 32'(chan_start), 32'd0);
    chk({tag, "_win_en"}, 32'(win_en), 32'd0);
    chk({tag, "_rst"}, 32'(mem_feat_rst), 32'd0);
    chk({tag, "_we"}, 32'(mem_feat_we), 32'd0);
    chk({tag, "_out_en"}, 32'(out_en), 32'd0);
  endtask

  initial begin
    logic seen;
    xrst = 1'b1; req = 1'b0; in_ch = '0; feat_cnt = '0; w_base = '0;
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    chk("reset_w_addr", 32'(w_addr), 32'd0);
    chk("reset_rd_addr", 32'(mem_feat_addr), 32'd0);
    chk("reset_wr_addr", 32'(mem_feat_addr_d1), 32'd0);
    @(posedge clk); #1;
    xrst = 1'b0;

    clear_mon(); start_req(1, 4, 'h010); wait_idle("single", 300); check_run("single", 1, 4, 'h010);
    clear_mon(); start_req(3, 2, 'h000); wait_idle("three", 400);  check_run("three", 3, 2, 'h000);
    clear_mon(); start_req(0, 4, 'h123); wait_idle("zero_ch", 20); check_run("zero_ch", 0, 4, 'h123);
    clear_mon(); start_req(2, 0, 'h040); wait_idle("zero_ft", 20); check_run("zero_ft", 2, 0, 'h040);
    clear_mon(); start_req(1, 3, 'hFFF); wait_idle("wrap", 300);   check_run("wrap", 1, 3, 'hFFF);

    // req while busy must not disturb the running job
    clear_mon();
    start_req(1, 4, 'h200);
    repeat (5) @(posedge clk);
    #1;
    in_ch = 8'd3; feat_cnt = 11'd7; w_base = 12'h555; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    wait_idle("busy", 300);
    check_run("busy", 1, 4, 'h200);

    // reset in the middle of CONV
    clear_mon();
    start_req(2, 8, 'h100);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (win_en) begin
        seen = 1'b1;
        break;
      end
    end
    chk("abort_reach_conv", 32'(seen), 32'd1);
    @(posedge clk); #1;
    xrst = 1'b1;
    @(posedge clk); #1;
    xrst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("abort_c%0d", i), {25'd0, ack, wreg_we, chan_start, win_en,
          mem_feat_rst, mem_feat_we, out_en}, 32'h40);
    end
    @(posedge clk); #1;
    clear_mon(); start_req(1, 4, 'h020); wait_idle("after_abort", 300); check_run("after_abort", 1, 4, 'h020);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/renkon_conv_seq.md
Name: renkon_conv_seq

Overview:
- Control sequencer that drives the control side of one renkon_conv unit.
- Loads the 25 kernel weights of each input channel into the weight register chain, then sweeps every output-map address.
- Emits the feature-memory read/write addresses, accumulate-reset, write-enable and output-enable strobes, aligned to the conv tree pipeline latency.
- Sits between the layer controller (req/ack) and the weight memory plus window buffer.

Parameters:
- DWIDTH, 16, data width; documentation only, no datapath here.
- FACCUM, 10, feature-memory address width.
- WADDR, 12, weight-memory address width.
- CHWIDTH, 8, input-channel count width.
- FSIZE2, 25, kernel taps per channel (5x5).
- TREE_LAT, 4, cycles from win_en to a valid tree result; must be >= 2.

Ports:
- clk  in  1  clock.
- xrst  in  1  reset.
- req  in  1  start pulse; sampled only in IDLE.
- in_ch  in  CHWIDTH  number of input channels.
- feat_cnt  in  FACCUM+1  output pixels per map.
- w_base  in  WADDR  weight-memory base address of this filter.
- ack  out  1  high when idle.
- w_addr  out  WADDR  weight-memory read address; memory read latency is 1 cycle.
- wreg_we  out  1  shift enable for the weight register, aligned with read_weight.
- chan_start  out  1  one-cycle pulse before each channel's sweep; clears the window buffer.
- win_en  out  1  advance the window buffer by one output position.
- mem_feat_addr  out  FACCUM  feature-memory read address.
- mem_feat_rst  out  1  accumulate reset (first channel); aligned with mem_feat_addr.
- mem_feat_addr_d1  out  FACCUM  feature-memory write address.
- mem_feat_we  out  1  feature-memory write enable; aligned with mem_feat_addr_d1.
- out_en  out  1  final-channel write; aligned with mem_feat_we.

Behaviour:
- Interface: one clock clk; reset xrst is synchronous and active-high.
- Reset values: ack=1; every other output 0; state IDLE; all pipeline valid bits cleared. Reset mid-operation aborts immediately and emits no further strobes.
- States:
  - IDLE -> WLOAD on req, latching in_ch, feat_cnt and w_base.
  - If the latched in_ch==0 or feat_cnt==0: IDLE -> DONE directly, with no strobes.
- WLOAD:
  - FSIZE2 cycles; w_addr = w_base + c*FSIZE2 + k, where k = 0..24 and c is the current channel.
  - wreg_we is high on the cycle after each address, giving exactly 25 pulses per channel.
  - The address adder wraps modulo 2^WADDR.
- WLAST: one cycle for the final wreg_we; chan_start=1.
- CONV:
  - feat_cnt consecutive cycles with win_en=1; position counter p = 0..feat_cnt-1.
  - Tag {valid, p, first = (c==0), last = (c==in_ch-1)} enters a delay line.
- Delay line (strobe timing):
  - mem_feat_addr = p and mem_feat_rst = first appear TREE_LAT-1 cycles after win_en, with read_feat valid at TREE_LAT.
  - mem_feat_addr_d1 = p and mem_feat_we = 1 appear one cycle later, at TREE_LAT.
  - out_en = last, on the same cycle as mem_feat_we.
  - Addresses hold their last value when not valid.
- DRAIN: TREE_LAT cycles after CONV, until the delay line is empty.
  - Then c+1 < in_ch -> WLOAD with c incremented.
  - Otherwise -> DONE.
  - Weights for the next channel are never loaded while the tree pipeline still holds the current channel.
- DONE: one cycle, then IDLE; ack rises on entry to IDLE.
- req while not IDLE: ignored.
- in_ch==1: mem_feat_rst and out_en both high for every pixel.
- feat_cnt == 2^FACCUM: p covers the full address space with no wrap.

Decomposition:
- Shared header constants: FSIZE2, TREE_LAT, FACCUM, WADDR, CHWIDTH, and the state encoding (IDLE, WLOAD, WLAST, CONV, DRAIN, DONE).
- One sub-module, renkon_conv_seq_dline: a parameterised-depth shift register carrying {valid, first, last, addr}, with synchronous clear on xrst.

Test Plan:
- Single channel, basic sweep: in_ch=1, feat_cnt=4, w_base=0x010, TREE_LAT=4.
  - w_addr 0x010..0x028; 25 wreg_we pulses.
  - win_en runs 4 cycles.
  - mem_feat_addr 0..3 with rst=1, starting 3 cycles after the first win_en.
  - we/out_en for addresses 0..3 one cycle later.
  - ack returns high.
- Three channels: in_ch=3, feat_cnt=2.
  - w_addr bases 0, 25, 50; mem_feat_rst only in channel 0; out_en only in channel 2.
  - No wreg_we while DRAIN is active.
- Zero counts: in_ch=0 (and separately feat_cnt=0).
  - ack drops for exactly 2 cycles; zero wreg_we, win_en and mem_feat_we.
- Wrap-around: w_base=0xFFF, in_ch=1.
  - w_addr 0xFFF, 0x000..0x017.
- Abort: xrst asserted mid-CONV.
  - Next cycle: all strobes 0, ack=1.
  - A following req runs a clean full sequence.
- Busy req: req pulsed during WLOAD.
  - Ignored; the sequence and strobe count are unchanged.
